out_mem_rd_arb: RTL and testbench
=================================

Name: out_mem_rd_arb

Overview:
Arbitrates the single output-memory read port between two requesters: requester 0 is host readback, requester 1 is the next-layer input loader. Each granted request is a burst of consecutive output-memory rows, one address broadcast to all NUM_BANK banks per beat. Read data is routed back to the owning requester with last-beat tagging. Reads are held off while the master controller is writing tiles into output memory.

Parameters:
NUM_BANK, 16, output-memory banks (= SYS_COL)
DATA_WIDTH, 32, bits per bank word (= PSUM_WIDTH)
ADDR_WIDTH, 16, row address width
MAX_BURST, 64, maximum beats per grant
RD_LATENCY, 1, memory read latency in cycles (at least 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req  in  2  per-requester request; held with addr/len until gnt
addr0, addr1  in  ADDR_WIDTH  burst start row
len0, len1  in  $clog2(MAX_BURST)+1  burst beats
gnt  out  2  one-cycle accept pulse, one-hot
block_rd  in  1  master is writing output memory; stall issue
mem_rd_en  out  1  read strobe to all banks
mem_rd_addr  out  ADDR_WIDTH  row address to all banks
mem_rd_data  in  NUM_BANK*DATA_WIDTH  bank data, bank k at bits [k*DATA_WIDTH +: DATA_WIDTH]
rvalid  out  2  per-requester data valid
rlast  out  1  qualifies the final beat of a burst
rdata  out  NUM_BANK*DATA_WIDTH  mem_rd_data forwarded unchanged
busy  out  1  high in BURST or while responses are in flight

Behaviour:
- Reset: every output is 0, state is IDLE, priority pointer is 0, beat counter is 0, response pipeline is cleared. Reset mid-burst drops all in-flight responses, so rvalid is 0 in the cycle after reset.
- States: IDLE and BURST. All outputs are registered.
- IDLE:
  - If block_rd=0 and req≠0 at edge T, select a requester. If only one requests, it wins. If both request, the requester at the priority pointer wins.
  - At T+1: gnt[w]=1, state=BURST, base and length are latched, and the owner is latched.
  - The priority pointer moves to !w after each grant.
  - block_rd=1 in IDLE: no grant.
- Length rules: len=0 is treated as 1. len>MAX_BURST is clamped to MAX_BURST.
- BURST:
  - The first beat issues in the same cycle as gnt: mem_rd_en=1, mem_rd_addr=base+beat.
  - Addition is modulo 2^ADDR_WIDTH; wrap past all-ones goes to 0.
  - beat increments on each issued beat.
  - If block_rd=1, no issue that cycle: mem_rd_en=0 and beat holds.
  - After the last beat issues, the next state is IDLE. There is one arbitration bubble: the minimum gap between bursts is 1 cycle with mem_rd_en=0.
- Response pipeline:
  - Owner and last flag travel through a RD_LATENCY-deep shift register alongside mem_rd_en.
  - Data for a beat issued in cycle C appears in cycle C+RD_LATENCY with rvalid[owner]=1 and rdata=mem_rd_data.
  - rlast=1 only on the final beat; rlast=0 whenever rvalid=0.
- req is ignored while in BURST. A requester whose request was not granted keeps req asserted.
- busy=1 from gnt until the last rvalid of the burst.
- block_rd asserted in the same cycle that IDLE would grant: the grant is deferred; block_rd has priority.

Test Plan:
- Single burst: req=01, addr0=0x0010, len0=4, block_rd=0.
  - Expect gnt=01 one cycle.
  - mem_rd_addr 0x10..0x13 on 4 consecutive cycles.
  - rvalid[0] for 4 cycles, one cycle later each; rlast on the 4th beat; rvalid[1] stays 0.
- Contention: req=11 from reset, len0=len1=2.
  - Expect gnt=01 first, one bubble, then gnt=10.
  - Re-assert both: gnt=01 again (alternation).
- Stall: len1=3 and block_rd=1 for 2 cycles after the first beat.
  - Expect addresses base, base+1, base+2 with a 2-cycle mem_rd_en gap.
  - rvalid gaps match; rlast only on the 3rd beat.
- Wrap and clamp: addr0=0xFFFE, len0=3 gives addresses 0xFFFE, 0xFFFF, 0x0000.
  - len0=0 gives exactly 1 beat.
  - len0=100 gives exactly 64 beats.
- Reset mid-burst: assert rst at beat 2 of an 8-beat burst.
  - Next cycle: gnt, rvalid, mem_rd_en, busy all 0.
  - Priority pointer is 0, so with req=11 the first grant goes to requester 0.
- Data integrity: drive mem_rd_data = {bank index, address} pattern with RD_LATENCY=2.
  - rdata matches the data for the issued address 2 cycles after issue, across all 16 banks.

Source files
------------

// File: rtl/out_mem_rd_arb.sv
// out_mem_rd_arb: two-way arbiter for the output-memory read port.
// Requester 0 is host readback, requester 1 is the next-layer input loader.
// A grant starts a burst of consecutive rows. Each beat broadcasts one row
// address to every bank. Returned data is tagged with its owner and a
// last-beat flag. While block_rd is high (master writing tiles), no grant
// and no beat is issued.
//
// Handshake contract: a requester raises req[i] and holds addr/len stable
// until it sees the one-cycle, one-hot gnt[i] pulse. Read data carries no
// backpressure. rvalid[i] marks a beat for requester i. rlast marks the
// final beat of a burst and is 0 whenever rvalid is 0.
module out_mem_rd_arb #(
    parameter int NUM_BANK   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_BURST  = 64,
    parameter int RD_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       req,
    input  logic [ADDR_WIDTH-1:0]            addr0,
    input  logic [ADDR_WIDTH-1:0]            addr1,
    input  logic [$clog2(MAX_BURST):0]       len0,
    input  logic [$clog2(MAX_BURST):0]       len1,
    output logic [1:0]                       gnt,
    input  logic                             block_rd,
    output logic                             mem_rd_en,
    output logic [ADDR_WIDTH-1:0]            mem_rd_addr,
    input  logic [NUM_BANK*DATA_WIDTH-1:0]   mem_rd_data,
    output logic [1:0]                       rvalid,
    output logic                             rlast,
    output logic [NUM_BANK*DATA_WIDTH-1:0]   rdata,
    output logic                             busy,
    output logic                             dbg_state
);

    localparam int LEN_W = $clog2(MAX_BURST) + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);
    localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Arbitration and burst-issue state
    state_t                  state_q, state_d;
    logic                    ptr_q, ptr_d;
    logic                    owner_q, owner_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        beat_q, beat_d;

    // Registered outputs toward requesters and memory
    logic [1:0]              gnt_q, gnt_d;
    logic                    rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic                    issue_last_q, issue_last_d;
    logic                    busy_q, busy_d;

    // Response pipeline: per-requester valid plus last flag, one stage per
    // cycle of memory latency, so the final stage lines up with mem_rd_data.
    logic [RD_LATENCY-1:0][1:0] rv_q, rv_d;
    logic [RD_LATENCY-1:0]      lst_q, lst_d;

    // Arbitration temporaries
    logic                    sel_win;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [LEN_W-1:0]        sel_len;

    // A zero length still moves one row; oversize requests are cut to MAX_BURST.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] l);
        if (l == '0) begin
            eff_len = ONE_LEN;
        end else if (l > MAX_LEN) begin
            eff_len = MAX_LEN;
        end else begin
            eff_len = l;
        end
    endfunction

    // Next-state and next-output logic for the IDLE/BURST controller
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        base_d       = base_q;
        len_d        = len_q;
        beat_d       = beat_q;
        gnt_d        = 2'b00;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        issue_last_d = 1'b0;
        sel_win      = 1'b0;
        sel_addr     = '0;
        sel_len      = '0;

        case (state_q)
            IDLE: begin
                // block_rd outranks any pending request; the grant just waits.
                if (!block_rd && (req != 2'b00)) begin
                    if (req == 2'b11) begin
                        sel_win = ptr_q;
                    end else begin
                        sel_win = req[1];
                    end
                    sel_addr = sel_win ? addr1 : addr0;
                    sel_len  = eff_len(sel_win ? len1 : len0);

                    gnt_d        = sel_win ? 2'b10 : 2'b01;
                    state_d      = BURST;
                    base_d       = sel_addr;
                    len_d        = sel_len;
                    owner_d      = sel_win;
                    ptr_d        = ~sel_win;
                    // The first beat leaves together with the grant pulse.
                    rd_en_d      = 1'b1;
                    rd_addr_d    = sel_addr;
                    beat_d       = ONE_LEN;
                    issue_last_d = (sel_len == ONE_LEN);
                end
            end
            BURST: begin
                if (beat_q == len_q) begin
                    // All beats are out. Returning to IDLE costs one cycle,
                    // which is the arbitration bubble between bursts.
                    state_d = IDLE;
                    beat_d  = '0;
                end else if (!block_rd) begin
                    rd_en_d      = 1'b1;
                    rd_addr_d    = base_q + ADDR_WIDTH'(beat_q);
                    beat_d       = beat_q + ONE_LEN;
                    issue_last_d = ((beat_q + ONE_LEN) == len_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shift owner and last tags alongside the issued read strobe
    always_comb begin
        rv_d     = '0;
        lst_d    = '0;
        rv_d[0]  = rd_en_q ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
        lst_d[0] = rd_en_q & issue_last_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            rv_d[i]  = rv_q[i-1];
            lst_d[i] = lst_q[i-1];
        end
    end

    // busy covers the whole burst plus every response still in flight
    always_comb begin
        busy_d = (state_d == BURST) || (rv_d != '0);
    end

    // State and output registers; reset drops any in-flight responses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            owner_q      <= 1'b0;
            base_q       <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            gnt_q        <= 2'b00;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            issue_last_q <= 1'b0;
            busy_q       <= 1'b0;
            rv_q         <= '0;
            lst_q        <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            base_q       <= base_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            gnt_q        <= gnt_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            issue_last_q <= issue_last_d;
            busy_q       <= busy_d;
            rv_q         <= rv_d;
            lst_q        <= lst_d;
        end
    end

    assign gnt         = gnt_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = rd_addr_q;
    assign rvalid      = rv_q[RD_LATENCY-1];
    assign rlast       = lst_q[RD_LATENCY-1];
    assign rdata       = mem_rd_data;
    assign busy        = busy_q;
    assign dbg_state   = (state_q == BURST);

endmodule

// File: tb/tb_out_mem_rd_arb.sv
// Bench for out_mem_rd_arb: directed bursts, a latency-accurate memory model
// and a queue-based scoreboard checked by a separate monitor process.
module tb_out_mem_rd_arb;

    localparam int NB  = 16;
    localparam int DW  = 32;
    localparam int AW  = 16;
    localparam int MB  = 64;
    localparam int LAT = 2;
    localparam int LW  = $clog2(MB) + 1;
    localparam int W   = NB * DW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [1:0]     req = 2'b00;
    logic [AW-1:0]  addr0 = '0;
    logic [AW-1:0]  addr1 = '0;
    logic [LW-1:0]  len0 = '0;
    logic [LW-1:0]  len1 = '0;
    logic           block_rd = 1'b0;
    logic [1:0]     gnt;
    logic           mem_rd_en;
    logic [AW-1:0]  mem_rd_addr;
    logic [W-1:0]   mem_rd_data;
    logic [1:0]     rvalid;
    logic           rlast;
    logic [W-1:0]   rdata;
    logic           busy;
    logic           dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_gnt_cyc = 0;
    int last_iss_cyc = 0;

    // Scoreboard queues
    logic [AW-1:0]  exp_addr_q[$];
    logic [AW+1:0]  exp_resp_q[$];   // {owner, last, addr}
    logic [1:0]     exp_gnt_q[$];
    int             iss_q[$];
    logic [AW+1:0]  resp_e;
    int             iss_c;

    logic [AW-1:0]  mp [LAT];

    out_mem_rd_arb #(
        .NUM_BANK(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .MAX_BURST(MB), .RD_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .req(req),
        .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
        .gnt(gnt), .block_rd(block_rd),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .rvalid(rvalid), .rlast(rlast), .rdata(rdata),
        .busy(busy), .dbg_state(dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bank k returns {k, row address}
    function automatic logic [W-1:0] pattern(input logic [AW-1:0] a);
        logic [W-1:0] p;
        p = '0;
        for (int k = 0; k < NB; k++) begin
            p[k*DW +: DW] = {16'(k), a};
        end
        return p;
    endfunction

    // Memory with LAT cycles of read latency
    always @(posedge clk) begin
        mp[0] <= mem_rd_addr;
        for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
    always_comb mem_rd_data = pattern(mp[LAT-1]);

    function automatic int eff(input int l);
        if (l == 0) return 1;
        if (l > MB) return MB;
        return l;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compare every grant, issued address and response
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt != 2'b00) begin
                last_gnt_cyc = cyc;
                if (exp_gnt_q.size() == 0) chk("gnt_unexpected", W'(gnt), '0);
                else chk("gnt", W'(gnt), W'(exp_gnt_q.pop_front()));
            end
            if (mem_rd_en) begin
                last_iss_cyc = cyc;
                iss_q.push_back(cyc);
                if (exp_addr_q.size() == 0) chk("rd_addr_unexpected", W'(mem_rd_en), '0);
                else chk("rd_addr", W'(mem_rd_addr), W'(exp_addr_q.pop_front()));
            end
            if (rvalid != 2'b00) begin
                if (exp_resp_q.size() == 0) begin
                    chk("rvalid_unexpected", W'(rvalid), '0);
                end else begin
                    resp_e = exp_resp_q.pop_front();
                    chk("rvalid", W'(rvalid), resp_e[AW+1] ? W'(2) : W'(1));
                    chk("rlast", W'(rlast), W'(resp_e[AW]));
                    chk("rdata", rdata, pattern(resp_e[AW-1:0]));
                end
                if (iss_q.size() > 0) begin
                    iss_c = iss_q.pop_front();
                    chk("latency", W'(cyc - iss_c), W'(LAT));
                end
            end else begin
                chk("rlast_idle", W'(rlast), '0);
            end
        end
    end

    // Driver helpers
    task automatic push_exp(input int r, input logic [AW-1:0] a, input int l);
        int n;
        logic [AW-1:0] ai;
        n = eff(l);
        for (int i = 0; i < n; i++) begin
            ai = a + AW'(i);
            exp_addr_q.push_back(ai);
            exp_resp_q.push_back({r[0], (i == n - 1), ai});
        end
        exp_gnt_q.push_back(r == 0 ? 2'b01 : 2'b10);
    endtask

    task automatic wait_gnt(input int r);
        int t;
        t = 0;
        while (gnt[r] !== 1'b1 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) chk("gnt_timeout", W'(gnt), r == 0 ? W'(1) : W'(2));
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy === 1'b1 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) chk("busy_timeout", W'(busy), '0);
    endtask

    task automatic burst(input int r, input logic [AW-1:0] a, input int l,
                         input int pre_blk, input int stall);
        push_exp(r, a, l);
        if (r == 0) begin addr0 = a; len0 = LW'(l); end
        else begin addr1 = a; len1 = LW'(l); end
        req[r] = 1'b1;
        if (pre_blk > 0) block_rd = 1'b1;
        for (int i = 0; i < pre_blk; i++) begin
            @(posedge clk); #1;
            chk("gnt_blocked", W'(gnt), '0);
        end
        block_rd = 1'b0;
        wait_gnt(r);
        req[r] = 1'b0;
        if (stall > 0) begin
            block_rd = 1'b1;
            repeat (stall) begin @(posedge clk); #1; end
            block_rd = 1'b0;
        end
        wait_idle();
        chk("burst_span", W'(last_iss_cyc - last_gnt_cyc), W'(eff(l) - 1 + stall));
    endtask

    task automatic contend(input logic [AW-1:0] a0, input int l0,
                           input logic [AW-1:0] a1, input int l1, input int first);
        int second, g1, g2;
        second = 1 - first;
        push_exp(first, first == 0 ? a0 : a1, first == 0 ? l0 : l1);
        push_exp(second, second == 0 ? a0 : a1, second == 0 ? l0 : l1);
        addr0 = a0; len0 = LW'(l0);
        addr1 = a1; len1 = LW'(l1);
        req = 2'b11;
        wait_gnt(first);
        g1 = cyc;
        req[first] = 1'b0;
        wait_gnt(second);
        g2 = cyc;
        req[second] = 1'b0;
        chk("bubble_gap", W'(g2 - g1), W'(eff(first == 0 ? l0 : l1) + 1));
        wait_idle();
    endtask

    task automatic reset_mid_burst();
        exp_gnt_q.push_back(2'b01);
        exp_addr_q.push_back(16'h0100);
        exp_addr_q.push_back(16'h0101);
        addr0 = 16'h0100; len0 = LW'(8);
        req[0] = 1'b1;
        wait_gnt(0);
        req[0] = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_gnt", W'(gnt), '0);
        chk("rst_rvalid", W'(rvalid), '0);
        chk("rst_rd_en", W'(mem_rd_en), '0);
        chk("rst_busy", W'(busy), '0);
        chk("rst_state", W'(dbg_state), '0);
        rst = 1'b0;
        iss_q.delete();
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Directed sequence
    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_gnt", W'(gnt), '0);
        chk("reset_rvalid", W'(rvalid), '0);
        chk("reset_rlast", W'(rlast), '0);
        chk("reset_rd_en", W'(mem_rd_en), '0);
        chk("reset_rd_addr", W'(mem_rd_addr), '0);
        chk("reset_busy", W'(busy), '0);
        chk("reset_state", W'(dbg_state), '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Contention from reset: 0 first, then 1; again 0 first (alternation)
        contend(16'h0200, 2, 16'h0300, 2, 0);
        contend(16'h0210, 2, 16'h0310, 2, 0);
        // Single burst on requester 0
        burst(0, 16'h0010, 4, 0, 0);
        // Requester 1 with a 2-cycle stall after the first beat
        burst(1, 16'h0040, 3, 0, 2);
        // Address wrap, with block_rd holding off the grant for 2 cycles
        burst(0, 16'hFFFE, 3, 2, 0);
        // Length clamps
        burst(0, 16'h0500, 0, 0, 0);
        burst(0, 16'h0600, 100, 0, 0);
        // Reset in the middle of an 8-beat burst, then pointer back at 0
        reset_mid_burst();
        @(posedge clk); #1;
        contend(16'h0700, 1, 16'h0800, 5, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("addr_q_empty", W'(exp_addr_q.size()), '0);
        chk("resp_q_empty", W'(exp_resp_q.size()), '0);
        chk("gnt_q_empty", W'(exp_gnt_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
